sub3_pipe: RTL and testbench

- Pipelined three-operand signed subtractor: o_diff = i_A - i_B - i_C.
- Companion to the 3-input adder in the FFT datapath; provides the difference leg of butterfly and twiddle stages.
- Unlike the adder, carries a valid/ready stream handshake with backpressure, so it sits between buffered FFT stages.
- Adds overflow reporting and a delivered-result counter.

---
 rtl/sub3_pipe.sv | 101 ++++++++++
 tb/tb_sub3_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub3_pipe.sv
// Two-stage signed A - B - C with a valid/ready stream handshake, overflow flag and delivered-result counter.
// Optional macro SUB3_SAT_EN: o_diff saturates to the signed WORD_SIZE range instead of wrapping.
module sub3_pipe #(
    parameter int WORD_SIZE = 16,
    parameter int COUNT_W   = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic signed [WORD_SIZE-1:0] i_A,
    input  logic signed [WORD_SIZE-1:0] i_B,
    input  logic signed [WORD_SIZE-1:0] i_C,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic signed [WORD_SIZE-1:0] o_diff,
    output logic                        o_ovf,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [COUNT_W-1:0]          o_count
);

    localparam int W = WORD_SIZE;
    localparam logic signed [W+1:0] MAX_V = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] MIN_V = {3'b111, {(W-1){1'b0}}};

    function automatic logic ovf_of(input logic signed [W+1:0] d);
        return (d > MAX_V) || (d < MIN_V);
    endfunction

    function automatic logic signed [W-1:0] round_out(input logic signed [W+1:0] d);
`ifdef SUB3_SAT_EN
        if (d > MAX_V)
            return MAX_V[W-1:0];
        else if (d < MIN_V)
            return MIN_V[W-1:0];
        else
            return d[W-1:0];
`else
        return d[W-1:0];
`endif
    endfunction

    logic signed [W:0]   d1_in;
    logic signed [W:0]   d1_p1;
    logic signed [W-1:0] c_p1;
    logic                vld_p1;
    logic signed [W+1:0] d2;
    logic signed [W-1:0] diff_p2;
    logic                ovf_p2;
    logic                vld_p2;
    logic [COUNT_W-1:0]  count;
    logic                s1_en;
    logic                s2_en;

    assign s2_en   = !vld_p2 || i_ready;
    assign s1_en   = !vld_p1 || s2_en;
    assign o_ready = s1_en;

    assign d1_in = {i_A[W-1], i_A} - {i_B[W-1], i_B};
    assign d2    = {d1_p1[W], d1_p1} - {{2{c_p1[W-1]}}, c_p1};

    // Stage 1: exact A - B plus the pending C operand
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            vld_p1 <= 1'b0;
        else if (s1_en)
            vld_p1 <= i_valid;
    end

    always_ff @(posedge i_clk) begin
        if (s1_en) begin
            d1_p1 <= d1_in;
            c_p1  <= i_C;
        end
    end

    // Stage 2: output register; the W+2 bit difference is reduced here
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p2  <= 1'b0;
            diff_p2 <= '0;
            ovf_p2  <= 1'b0;
        end else if (s2_en) begin
            vld_p2  <= vld_p1;
            diff_p2 <= round_out(d2);
            ovf_p2  <= ovf_of(d2);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            count <= '0;
        else if (vld_p2 && i_ready)
            count <= count + COUNT_W'(1);
    end

    assign o_valid = vld_p2;
    assign o_diff  = diff_p2;
    assign o_ovf   = ovf_p2;
    assign o_count = count;

endmodule

// File: tb/tb_sub3_pipe.sv
// Randomized self-checking bench for sub3_pipe against a transaction-queue reference model.
module tb_sub3_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] a, b, c;
    logic        vld, rdy;
    logic        o_ready, o_ovf, o_valid;
    logic [15:0] o_diff;
    logic [7:0]  o_count;

    logic [15:0] a2, b2, c2;
    logic        vld2, rdy2;
    logic        o_ready2, o_ovf2, o_valid2;
    logic [15:0] o_diff2;
    logic [1:0]  o_count2;

    int checks = 0;
    int errors = 0;

    sub3_pipe #(.WORD_SIZE(16), .COUNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_A(a), .i_B(b), .i_C(c), .i_valid(vld),
        .o_ready(o_ready), .o_diff(o_diff), .o_ovf(o_ovf), .o_valid(o_valid),
        .i_ready(rdy), .o_count(o_count)
    );

    sub3_pipe #(.WORD_SIZE(16), .COUNT_W(2)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_A(a2), .i_B(b2), .i_C(c2), .i_valid(vld2),
        .o_ready(o_ready2), .o_diff(o_diff2), .o_ovf(o_ovf2), .o_valid(o_valid2),
        .i_ready(rdy2), .o_count(o_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] diff;
        logic        ovf;
        int          acc;
    } item_t;

    item_t      q[$];
    int         edge_n = 0;
    logic [7:0] cnt_m  = 0;

    function automatic void ref_calc(input logic [15:0] ra, input logic [15:0] rb,
                                     input logic [15:0] rc,
                                     output logic [15:0] d, output logic v);
        int t;
        t = int'($signed(ra)) - int'($signed(rb)) - int'($signed(rc));
        v = (t > 32767) || (t < -32768);
`ifdef SUB3_SAT_EN
        if (t > 32767)       d = 16'h7FFF;
        else if (t < -32768) d = 16'h8000;
        else                 d = t[15:0];
`else
        d = t[15:0];
`endif
    endfunction

    // head result is visible once it has been in flight for two edges
    function automatic bit m_valid();
        return (q.size() > 0) && (edge_n >= q[0].acc + 1);
    endfunction

    function automatic bit m_ready();
        return (q.size() < 2) || rdy;
    endfunction

    task automatic step();
        bit          dlv;
        bit          acc_ok;
        logic [15:0] d;
        logic        v;
        @(posedge clk);
        if (rst) begin
            q.delete();
            cnt_m = 0;
        end else begin
            dlv    = m_valid() && rdy;
            acc_ok = vld && m_ready();
            edge_n++;
            if (dlv) begin
                void'(q.pop_front());
                cnt_m++;
            end
            if (acc_ok) begin
                ref_calc(a, b, c, d, v);
                q.push_back('{diff: d, ovf: v, acc: edge_n});
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_triple(output logic [15:0] ra, output logic [15:0] rb,
                               output logic [15:0] rc);
        ra = 16'($urandom());
        rb = 16'($urandom());
        rc = 16'($urandom());
        if ($urandom_range(0, 5) == 0) ra = 16'h7FFF;
        if ($urandom_range(0, 5) == 0) ra = 16'h8000;
        if ($urandom_range(0, 5) == 0) rb = 16'h8000;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (o_valid !== 1'b0 || o_count !== 8'd0 || o_diff !== 16'd0 || o_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b count=%0d diff=%h ovf=%b, required all zero",
                     o_valid, o_count, o_diff, o_ovf);
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b, required ready=1 valid=0", o_ready, o_valid);
        end
    endtask

    task automatic test_basic();
        rdy = 1'b1; vld = 1'b1; a = 16'd100; b = 16'd30; c = 16'd20;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (o_valid !== m_valid() || o_ready !== m_ready() || o_count !== cnt_m) begin
                errors++;
                $display("FAIL basic_ctrl k=%0d: valid=%b ready=%b count=%0d, required %b %b %0d",
                         k, o_valid, o_ready, o_count, m_valid(), m_ready(), cnt_m);
            end
            if (k == 2) begin
                checks++;
                if (o_valid !== 1'b1 || o_diff !== 16'd50 || o_ovf !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_result: valid=%b diff=%0d ovf=%b, required 1 50 0",
                             o_valid, o_diff, o_ovf);
                end
            end
            if (k == 3) begin
                checks++;
                if (o_count !== 8'd1) begin
                    errors++;
                    $display("FAIL basic_count: count=%0d, required 1", o_count);
                end
            end
            step();
            vld = 1'b0;
        end
    endtask

    task automatic test_overflow();
        logic [15:0] e1, e2;
`ifdef SUB3_SAT_EN
        e1 = 16'h8000; e2 = 16'h7FFF;
`else
        e1 = 16'h7FFF; e2 = 16'h8001;
`endif
        rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            vld = (k < 2);
            if (k == 0) begin a = 16'h8000; b = 16'h0001; c = 16'h0000; end
            if (k == 1) begin a = 16'h7FFF; b = 16'hFFFF; c = 16'hFFFF; end
            #1;
            checks++;
            if (o_valid !== m_valid() || (m_valid() && (o_diff !== q[0].diff || o_ovf !== q[0].ovf))) begin
                errors++;
                $display("FAIL ovf_model k=%0d: valid=%b diff=%h ovf=%b", k, o_valid, o_diff, o_ovf);
            end
            if (k == 2 || k == 3) begin
                checks++;
                if (o_valid !== 1'b1 || o_ovf !== 1'b1 || o_diff !== (k == 2 ? e1 : e2)) begin
                    errors++;
                    $display("FAIL ovf_case%0d: valid=%b diff=%h ovf=%b, required 1 %h 1",
                             k - 1, o_valid, o_diff, o_ovf, (k == 2 ? e1 : e2));
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got[$];
        int          gidx[$];
        logic [7:0]  cnt0;
        cnt0 = cnt_m;
        rdy = 1'b0; vld = 1'b1;
        a = 16'd10; b = 16'd1; c = 16'd1;
        step();
        a = 16'd20; b = 16'd2; c = 16'd2;
        step();
        a = 16'd30; b = 16'd3; c = 16'd3;
        #1;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_full: ready=%b, required 0", o_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            checks++;
            if (o_valid !== 1'b1 || o_diff !== 16'd8 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold k=%0d: valid=%b diff=%0d ready=%b, required 1 8 0",
                         k, o_valid, o_diff, o_ready);
            end
        end
        rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (o_valid) begin
                got.push_back(o_diff);
                gidx.push_back(k);
            end
            step();
            vld = 1'b0;
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_drain_count: delivered=%0d, required 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== 16'(8 * (i + 1)) || gidx[i] != i) begin
                    errors++;
                    $display("FAIL bp_order i=%0d: diff=%0d at cycle %0d, required %0d at cycle %0d",
                             i, got[i], gidx[i], 8 * (i + 1), i);
                end
            end
        end
        checks++;
        if (o_count !== 8'(cnt0 + 8'd3)) begin
            errors++;
            $display("FAIL bp_counter: count=%0d, required %0d", o_count, 8'(cnt0 + 8'd3));
        end
    endtask

    task automatic test_streaming();
        rdy = 1'b1;
        for (int k = 0; k < 24; k++) begin
            vld = (k < 20);
            rand_triple(a, b, c);
            #1;
            checks++;
            if (o_valid !== m_valid() || o_ready !== 1'b1 || o_count !== cnt_m ||
                (m_valid() && (o_diff !== q[0].diff || o_ovf !== q[0].ovf))) begin
                errors++;
                $display("FAIL stream k=%0d: valid=%b ready=%b diff=%h ovf=%b count=%0d",
                         k, o_valid, o_ready, o_diff, o_ovf, o_count);
            end
            if (k >= 2 && k < 22) begin
                checks++;
                if (o_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_gap k=%0d: valid=%b, required 1", k, o_valid);
                end
            end
            step();
        end
    endtask

    task automatic test_random_handshake();
        for (int k = 0; k < 200; k++) begin
            vld = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rand_triple(a, b, c);
            #1;
            checks++;
            if (o_valid !== m_valid() || o_ready !== m_ready() || o_count !== cnt_m ||
                (m_valid() && (o_diff !== q[0].diff || o_ovf !== q[0].ovf))) begin
                errors++;
                $display("FAIL random k=%0d: valid=%b ready=%b diff=%h ovf=%b count=%0d, required %b %b %h %b %0d",
                         k, o_valid, o_ready, o_diff, o_ovf, o_count, m_valid(), m_ready(),
                         (m_valid() ? q[0].diff : 16'h0), (m_valid() ? q[0].ovf : 1'b0), cnt_m);
            end
            step();
        end
        vld = 1'b0; rdy = 1'b1;
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic test_reset_midflight();
        rdy = 1'b0; vld = 1'b1;
        rand_triple(a, b, c);
        step();
        rand_triple(a, b, c);
        step();
        vld = 1'b0;
        step();
        rst = 1'b1;
        #1;
        q.delete();
        cnt_m = 0;
        checks++;
        if (o_valid !== 1'b0 || o_count !== 8'd0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_immediate: valid=%b count=%0d ready=%b, required 0 0 1",
                     o_valid, o_count, o_ready);
        end
        step();
        rst = 1'b0;
        rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (o_valid !== 1'b0 || o_count !== 8'd0) begin
                errors++;
                $display("FAIL midreset_stale k=%0d: valid=%b count=%0d, required 0 0", k, o_valid, o_count);
            end
            step();
        end
    endtask

    task automatic test_count_wrap();
        int n_dlv;
        rdy2 = 1'b1; vld2 = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            rand_triple(a2, b2, c2);
            step();
            if (n == 5) vld2 = 1'b0;
            n_dlv = (n < 2) ? 0 : ((n - 2 > 5) ? 5 : n - 2);
            #1;
            checks++;
            if (o_count2 !== 2'(n_dlv % 4)) begin
                errors++;
                $display("FAIL count_wrap n=%0d: count=%0d, required %0d", n, o_count2, n_dlv % 4);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a = '0; b = '0; c = '0; vld = 1'b0; rdy = 1'b0;
        a2 = '0; b2 = '0; c2 = '0; vld2 = 1'b0; rdy2 = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_streaming();
        test_random_handshake();
        test_reset_midflight();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
